// File: rtl/probe_conditioner.sv
// probe_conditioner: turns raw asynchronous probe lines into clean, single-domain
// probe pulses (synchronize, debounce, edge/level select, stretch) for bpCorrelator.
module probe_conditioner #(
  parameter int N_PROBE     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 4,
  parameter int STRETCH_W   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cg,
  input  logic [N_PROBE-1:0]    i_probeRaw,
  input  logic [2*N_PROBE-1:0]  i_cfgMode,
  input  logic [DEBOUNCE_W-1:0] i_cfgDebounce,
  input  logic [STRETCH_W-1:0]  i_cfgStretch,
  input  logic                  i_glitchClr,
  output logic [N_PROBE-1:0]    o_probe,
  output logic [N_PROBE-1:0]    o_glitch
);

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  logic [N_PROBE-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_PROBE-1:0]                  sync_out;
  logic [N_PROBE-1:0]                  deb_q, deb_d;
  logic [N_PROBE-1:0][DEBOUNCE_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [N_PROBE-1:0]                  update_s;
  logic [N_PROBE-1:0]                  glitch_set_s;
  logic [N_PROBE-1:0]                  event_s;
  logic [N_PROBE-1:0][STRETCH_W-1:0]   stretch_cnt_q, stretch_cnt_d;
  logic [N_PROBE-1:0]                  probe_q, probe_d;
  logic [N_PROBE-1:0]                  glitch_q, glitch_d;

  function automatic logic edge_event(input logic [1:0] mode, input logic upd,
                                      input logic new_level);
    case (mode)
      MODE_RISE: edge_event = upd & new_level;
      MODE_FALL: edge_event = upd & ~new_level;
      MODE_BOTH: edge_event = upd;
      default:   edge_event = 1'b0;
    endcase
  endfunction

  // Synchronizer shifts every cycle, independent of the clock gate.
  always_comb begin
    sync_d   = sync_q;
    sync_out = '0;
    for (int p = 0; p < N_PROBE; p++) begin
      sync_d[p]   = {sync_q[p][SYNC_STAGES-2:0], i_probeRaw[p]};
      sync_out[p] = sync_q[p][SYNC_STAGES-1];
    end
  end

  always_comb begin
    deb_d        = deb_q;
    deb_cnt_d    = deb_cnt_q;
    update_s     = '0;
    glitch_set_s = '0;
    for (int p = 0; p < N_PROBE; p++) begin
      if (!i_cg) begin
        deb_d[p]     = deb_q[p];
        deb_cnt_d[p] = deb_cnt_q[p];
      end else if (sync_out[p] == deb_q[p]) begin
        deb_cnt_d[p]    = '0;
        glitch_set_s[p] = (deb_cnt_q[p] != '0);
      end else if (deb_cnt_q[p] >= i_cfgDebounce) begin
        // >= so that lowering D below a running count updates on the next differing cycle
        deb_d[p]     = sync_out[p];
        deb_cnt_d[p] = '0;
        update_s[p]  = 1'b1;
      end else begin
        deb_cnt_d[p] = deb_cnt_q[p] + DEBOUNCE_W'(1);
      end
    end
  end

  always_comb begin
    event_s       = '0;
    probe_d       = probe_q;
    stretch_cnt_d = stretch_cnt_q;
    for (int p = 0; p < N_PROBE; p++) begin
      event_s[p] = edge_event(i_cfgMode[2*p +: 2], update_s[p], deb_d[p]);
      if (!i_cg) begin
        probe_d[p]       = probe_q[p];
        stretch_cnt_d[p] = stretch_cnt_q[p];
      end else if (i_cfgMode[2*p +: 2] == MODE_LEVEL) begin
        probe_d[p]       = deb_d[p];
        stretch_cnt_d[p] = '0;
      end else if (event_s[p]) begin
        probe_d[p]       = 1'b1;
        stretch_cnt_d[p] = i_cfgStretch;
      end else if (stretch_cnt_q[p] != '0) begin
        probe_d[p]       = 1'b1;
        stretch_cnt_d[p] = stretch_cnt_q[p] - STRETCH_W'(1);
      end else begin
        probe_d[p]       = 1'b0;
        stretch_cnt_d[p] = '0;
      end
    end
  end

  // Sticky glitch flag: a new rejection beats a simultaneous clear.
  always_comb begin
    glitch_d = glitch_q;
    for (int p = 0; p < N_PROBE; p++) begin
      if (glitch_set_s[p]) begin
        glitch_d[p] = 1'b1;
      end else if (i_glitchClr) begin
        glitch_d[p] = 1'b0;
      end else begin
        glitch_d[p] = glitch_q[p];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync_q        <= '0;
      deb_q         <= '0;
      deb_cnt_q     <= '0;
      stretch_cnt_q <= '0;
      probe_q       <= '0;
      glitch_q      <= '0;
    end else begin
      sync_q        <= sync_d;
      deb_q         <= deb_d;
      deb_cnt_q     <= deb_cnt_d;
      stretch_cnt_q <= stretch_cnt_d;
      probe_q       <= probe_d;
      glitch_q      <= glitch_d;
    end
  end

  assign o_probe  = probe_q;
  assign o_glitch = glitch_q;

endmodule

// File: tb/tb_probe_conditioner.sv
// tb_probe_conditioner: directed scenarios plus randomized traffic, each checked
// against a cycle-level behavioural model of the probe conditioning rules.
module tb_probe_conditioner;

  localparam int N    = 4;
  localparam int SYNC = 2;

  logic           clk = 1'b0;
  logic           rst, cg, clr;
  logic [N-1:0]   raw;
  logic [2*N-1:0] mode;
  logic [3:0]     dbn, str;
  logic [N-1:0]   o_probe, o_glitch;

  int n_cmp = 0;
  int n_err = 0;

  // model state: hist[k] is the raw sample taken k+1 edges ago
  logic [N-1:0] hist [SYNC];
  logic [N-1:0] m_deb, m_probe, m_glitch;
  int           m_run [N];
  int           m_rem [N];

  probe_conditioner #(.N_PROBE(N), .SYNC_STAGES(SYNC), .DEBOUNCE_W(4), .STRETCH_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_probeRaw(raw), .i_cfgMode(mode),
    .i_cfgDebounce(dbn), .i_cfgStretch(str), .i_glitchClr(clr),
    .o_probe(o_probe), .o_glitch(o_glitch)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < SYNC; k++) hist[k] = '0;
    m_deb = '0; m_probe = '0; m_glitch = '0;
    for (int p = 0; p < N; p++) begin m_run[p] = 0; m_rem[p] = 0; end
  endfunction

  function automatic void model_edge();
    logic [N-1:0] seen;
    if (!rst) begin
      model_reset();
      return;
    end
    seen = hist[SYNC-1];
    for (int k = SYNC-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = raw;
    for (int p = 0; p < N; p++) begin
      bit upd, gset, ev;
      int md;
      upd = 0; gset = 0;
      md  = int'(mode[2*p +: 2]);
      if (cg) begin
        if (seen[p] == m_deb[p]) begin
          gset = (m_run[p] != 0);
          m_run[p] = 0;
        end else if (m_run[p] >= int'(dbn)) begin
          m_deb[p] = seen[p];
          m_run[p] = 0;
          upd = 1;
        end else begin
          m_run[p]++;
        end
        ev = upd && (md == 3 || (md == 1 && m_deb[p]) || (md == 2 && !m_deb[p]));
        if (md == 0) begin
          m_probe[p] = m_deb[p]; m_rem[p] = 0;
        end else if (ev) begin
          m_probe[p] = 1'b1; m_rem[p] = int'(str);
        end else if (m_rem[p] > 0) begin
          m_probe[p] = 1'b1; m_rem[p]--;
        end else begin
          m_probe[p] = 1'b0;
        end
      end
      if (gset) m_glitch[p] = 1'b1;
      else if (clr) m_glitch[p] = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (o_probe !== 4'b0000 || o_glitch !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_state probe=%b glitch=%b required 0000/0000", o_probe, o_glitch);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_rise_d0();
    mode = 8'h55; dbn = 4'd0; str = 4'd0; raw = '0;
    for (int i = 0; i < 10; i++) tick();
    raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (o_probe[0] !== (k == 3)) begin
        n_err++;
        $display("FAIL rise_d0 k=%0d probe0=%b required %b", k, o_probe[0], (k == 3));
      end
      n_cmp++;
      if (o_probe !== m_probe || o_glitch !== m_glitch) begin
        n_err++;
        $display("FAIL rise_d0_model k=%0d probe=%b/%b glitch=%b/%b", k, o_probe, m_probe, o_glitch, m_glitch);
      end
    end
  endtask

  task automatic test_glitch();
    mode = 8'h55; dbn = 4'd3; str = 4'd0; raw = '0;
    for (int i = 0; i < 12; i++) tick();
    raw[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) raw[1] = 1'b0;
      n_cmp++;
      if (o_probe[1] !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_nopulse k=%0d probe1=%b required 0", k, o_probe[1]);
      end
    end
    n_cmp++;
    if (o_glitch[1] !== 1'b1 || o_glitch !== m_glitch) begin
      n_err++;
      $display("FAIL glitch_sticky glitch=%b required bit1 set, model %b", o_glitch, m_glitch);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_cmp++;
    if (o_glitch[1] !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_clear glitch1=%b required 0", o_glitch[1]);
    end
    raw[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (o_probe[1] !== (k == 6) || o_probe !== m_probe) begin
        n_err++;
        $display("FAIL debounce_d3 k=%0d probe=%b required bit1=%b model %b", k, o_probe, (k == 6), m_probe);
      end
    end
  endtask

  task automatic test_stretch_both();
    int ones;
    mode = 8'hFF; dbn = 4'd0; str = 4'd5; raw = '0;
    for (int i = 0; i < 12; i++) tick();
    for (int t = 0; t < 4; t++) begin
      raw[2] = ~raw[2];
      ones = 0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (o_probe[2] === 1'b1) ones++;
        n_cmp++;
        if (o_probe !== m_probe) begin
          n_err++;
          $display("FAIL stretch_model t=%0d k=%0d probe=%b required %b", t, k, o_probe, m_probe);
        end
      end
      n_cmp++;
      if (ones != 6) begin
        n_err++;
        $display("FAIL stretch_width t=%0d width=%0d required 6", t, ones);
      end
    end
    raw[2] = ~raw[2];
    ones = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) raw[2] = ~raw[2];
      if (o_probe[2] === 1'b1) ones++;
    end
    n_cmp++;
    if (ones != 9) begin
      n_err++;
      $display("FAIL retrigger_width width=%0d required 9", ones);
    end
  endtask

  task automatic test_level();
    mode = 8'h00; dbn = 4'd2; str = 4'd7; raw = '0;
    for (int i = 0; i < 12; i++) tick();
    raw[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (o_probe[3] !== (k >= 5) || o_probe !== m_probe) begin
        n_err++;
        $display("FAIL level_rise k=%0d probe=%b required bit3=%b model %b", k, o_probe, (k >= 5), m_probe);
      end
    end
    raw[3] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) raw[3] = 1'b1;
      n_cmp++;
      if (o_probe[3] !== 1'b1) begin
        n_err++;
        $display("FAIL level_glitch k=%0d probe3=%b required 1", k, o_probe[3]);
      end
    end
    raw[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (o_probe[3] !== (k < 5) || o_glitch !== m_glitch) begin
        n_err++;
        $display("FAIL level_fall k=%0d probe3=%b required %b glitch=%b/%b", k, o_probe[3], (k < 5), o_glitch, m_glitch);
      end
    end
  endtask

  task automatic test_gate();
    int ones;
    mode = 8'h55; dbn = 4'd0; str = 4'd5; raw = '0;
    for (int i = 0; i < 12; i++) tick();
    raw[0] = 1'b1;
    ones = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 3) begin cg = 1'b0; raw[2] = 1'b1; end
      if (k == 7) begin
        cg = 1'b1;
        n_cmp++;
        if (o_probe[2] !== 1'b0) begin
          n_err++;
          $display("FAIL gate_hold probe2=%b required 0", o_probe[2]);
        end
      end
      if (k == 8) begin
        n_cmp++;
        if (o_probe[2] !== 1'b1) begin
          n_err++;
          $display("FAIL gate_sync_capture probe2=%b required 1", o_probe[2]);
        end
      end
      if (o_probe[0] === 1'b1) ones++;
      n_cmp++;
      if (o_probe !== m_probe) begin
        n_err++;
        $display("FAIL gate_model k=%0d probe=%b required %b", k, o_probe, m_probe);
      end
    end
    n_cmp++;
    if (ones != 10) begin
      n_err++;
      $display("FAIL gate_width width=%0d required 10", ones);
    end
  endtask

  task automatic test_reset_mid();
    int ones;
    mode = 8'h55; dbn = 4'd2; str = 4'd5; raw = '0;
    for (int i = 0; i < 12; i++) tick();
    raw[1] = 1'b1; raw[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) raw[3] = 1'b0;
    end
    n_cmp++;
    if (o_probe[1] !== 1'b1 || o_glitch[3] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_pre probe=%b glitch=%b required bit1/bit3 set", o_probe, o_glitch);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (o_probe !== 4'b0000 || o_glitch !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid probe=%b glitch=%b required 0000/0000", o_probe, o_glitch);
    end
    tick();
    rst = 1'b1; dbn = 4'd0; str = 4'd0;
    ones = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (o_probe[1] === 1'b1) ones++;
      n_cmp++;
      if (o_probe[1] !== (k == 3)) begin
        n_err++;
        $display("FAIL reset_release k=%0d probe1=%b required %b", k, o_probe[1], (k == 3));
      end
    end
    n_cmp++;
    if (ones != 1) begin
      n_err++;
      $display("FAIL reset_release_count pulses=%0d required 1", ones);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        mode = 8'($urandom);
        dbn  = 4'($urandom_range(0, 6));
        str  = 4'($urandom_range(0, 7));
      end else if (c % 37 == 0) begin
        dbn  = 4'($urandom_range(0, 6));
      end
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 5) == 0) raw[p] = ~raw[p];
      cg  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) != 0);
      tick();
      n_cmp++;
      if (o_probe !== m_probe || o_glitch !== m_glitch) begin
        n_err++;
        $display("FAIL random c=%0d probe=%b required %b glitch=%b required %b", c, o_probe, m_probe, o_glitch, m_glitch);
      end
    end
    rst = 1'b1; cg = 1'b1; clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cg = 1'b1; clr = 1'b0; raw = '0;
    mode = 8'h55; dbn = 4'd0; str = 4'd0;
    model_reset();
    test_reset();
    test_rise_d0();
    test_glitch();
    test_stretch_both();
    test_level();
    test_gate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
